skolem_sweep_ctrl: RTL
======================

Name: skolem_sweep_ctrl

Overview:
Exhaustive-check sequencer for a combinational Skolem-function netlist generated by synthesis. It steps through all 2^N_IN input assignments, drives each onto the netlist inputs, and waits a configurable settle time. It then samples an external specification checker's verdict, counts violations and latches the first counterexample. It sits in the post-synthesis validation harness, between the bench/host control and the netlist-plus-checker pair.

Parameters:
N_IN, 3, number of universally quantified netlist inputs (vector width)
N_OUT, 2, number of Skolem outputs observed
SETTLE, 1, cycles the vector is held before sampling (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin sweep (accepted only in IDLE or DONE)
abort  input  1  terminate sweep, return to IDLE
stop_on_fail  input  1  sampled at start acceptance; 1 = finish at first violation
sk_in  output  N_IN  assignment driven to netlist inputs
sk_out  input  N_OUT  netlist outputs for current sk_in
spec_ok  input  1  checker verdict for (sk_in, sk_out); valid in CHECK
busy  output  1  high in APPLY/CHECK
done  output  1  high in DONE; held until next start or abort
pass  output  1  valid when done; 1 iff fail_cnt==0
fail_cnt  output  N_IN+1  number of violating assignments, saturates at 2^N_IN
cex_valid  output  1  first counterexample captured
cex_in  output  N_IN  assignment of first violation
cex_out  output  N_OUT  sk_out at first violation

Behaviour:
- Synchronous active-high reset on clk. Reset values: state=IDLE, sk_in=0, busy=0, done=0, pass=0, fail_cnt=0, cex_valid=0, cex_in=0, cex_out=0, settle counter=0.
- Reset mid-sweep returns to IDLE in the following cycle. Captured results are lost.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE + start (no abort): fail_cnt, cex_*, pass and done are cleared. sk_in=0, settle counter=0, stop_on_fail latched. Next state is APPLY.
- APPLY: sk_in held stable. The counter increments each cycle. After SETTLE cycles in APPLY, go to CHECK.
- CHECK: spec_ok and sk_out are sampled at the end of this cycle.
  - If !spec_ok: fail_cnt++ (saturating).
  - If !spec_ok and !cex_valid: cex_valid=1, cex_in=sk_in, cex_out=sk_out.
  - If (!spec_ok and latched stop_on_fail) or sk_in == all-ones: go to DONE.
  - Otherwise: sk_in++, counter=0, go to APPLY.
- DONE: done=1, pass=(fail_cnt==0 after final update), busy=0. Remains in DONE until start, abort or rst.
- Per-vector cost is SETTLE+1 cycles. A full sweep with no early stop asserts done exactly 2^N_IN*(SETTLE+1)+1 cycles after the start-acceptance edge. Defaults: 17.
- sk_in increments by 1. There is no wrap: the all-ones vector is terminal, and the counter uses N_IN bits only.
- start while busy: ignored.
- abort in any state: go to IDLE next cycle, with done=0, busy=0, pass=0. Counters and cex are retained for debug.
- abort and start in the same cycle: abort wins, start is ignored.
- rst dominates abort and start.
- spec_ok and sk_out are don't-care outside CHECK. X on them outside CHECK must not propagate to any register.
- N_IN=1 is legal: 2 vectors.

Decomposition:
- Package skolem_sweep_pkg holds:
  - typedef sweep_state_t enum {IDLE, APPLY, CHECK, DONE};
  - the localparam function for total sweep cycles;
  - the default SETTLE constant.
- One natural sub-module: sweep_settle_timer, a loadable down-counter producing an expire pulse after SETTLE cycles, reused by other harness sequencers.
- The vector counter and result registers stay in the top module.

Test Plan:
- Clean sweep: N_IN=3, SETTLE=1, spec_ok tied 1, start pulse at cycle 0 -> sk_in walks 0..7, each held 1 APPLY + 1 CHECK cycle. done=1 at cycle 17 with pass=1, fail_cnt=0, cex_valid=0.
- Single violation: bench model drops spec_ok only for sk_in=5 (sk_out=2'b10), stop_on_fail=0 -> full sweep completes. fail_cnt=1, cex_in=3'b101, cex_out=2'b10, pass=0, done at cycle 17.
- Early stop: violations at sk_in=2 and 6, stop_on_fail=1 -> done after the CHECK of vector 2 (cycle 7). fail_cnt=1, cex_in=3'b010, and sk_in is never 3.
- Multiple violations without stop: spec_ok=0 for all 8 vectors -> fail_cnt=8, cex_in=0, pass=0.
- Abort and restart: abort at cycle 6, then start at cycle 9 -> idle at cycle 7 with done=0. Restart resets fail_cnt/cex and completes at cycle 9+17.
- Control corners:
  - start while busy: no effect on sk_in sequence.
  - start+abort together in IDLE: stays IDLE.
  - rst at cycle 10 of a sweep: all outputs at reset values at cycle 11.
  - SETTLE=3: each vector held 3 cycles, done at 8*4+1=33.

Source files
------------

// File: rtl/skolem_sweep_pkg.sv
// Shared types and constants for the Skolem netlist sweep harness.
package skolem_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int unsigned DEFAULT_SETTLE = 1;

  // Cycles from the cycle carrying start to the cycle where done is first high,
  // for a full sweep without early stop.
  function automatic int unsigned sweep_cycles(input int unsigned n_in,
                                               input int unsigned settle);
    return ((32'd1 << n_in) * (settle + 32'd1)) + 32'd1;
  endfunction

endpackage : skolem_sweep_pkg

// File: rtl/sweep_settle_timer.sv
// Loadable settle down-counter.
// Ports: clk, rst (sync, active-high), load (preset for a new hold window),
//        en (count this cycle), expire_c (combinational: last cycle of the window).
module sweep_settle_timer
  import skolem_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned   CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  // Preset to SETTLE-1 so the window covers exactly SETTLE enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire_c = en && (cnt == '0);

endmodule : sweep_settle_timer

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive-check sequencer for a combinational Skolem-function netlist.
// Walks sk_in through every assignment, holds each SETTLE cycles, samples the
// checker verdict in CHECK, counts violations and keeps the first counterexample.
// Ports: clk/rst (sync active-high); start/abort/stop_on_fail control;
//        sk_in -> netlist, sk_out/spec_ok <- netlist+checker;
//        busy/done/pass/fail_cnt/cex_valid/cex_in/cex_out status (all registered).
module skolem_sweep_ctrl
  import skolem_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             stop_on_fail,
  output logic [N_IN-1:0]  sk_in,
  input  logic [N_OUT-1:0] sk_out,
  input  logic             spec_ok,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_cnt,
  output logic             cex_valid,
  output logic [N_IN-1:0]  cex_in,
  output logic [N_OUT-1:0] cex_out
);

  localparam logic [N_IN:0]   FAIL_MAX = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  sweep_state_t      state, state_d;
  logic [N_IN-1:0]   sk_in_d, cex_in_d;
  logic [N_OUT-1:0]  cex_out_d;
  logic [N_IN:0]     fail_cnt_d, fail_upd;
  logic              busy_d, done_d, pass_d, cex_valid_d;
  logic              stop_lat, stop_lat_d;
  logic              tmr_load, tmr_en, tmr_expire_c;

  sweep_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .expire_c (tmr_expire_c)
  );

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sk_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_cnt  <= '0;
      cex_valid <= 1'b0;
      cex_in    <= '0;
      cex_out   <= '0;
      stop_lat  <= 1'b0;
    end else begin
      state     <= state_d;
      sk_in     <= sk_in_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_cnt  <= fail_cnt_d;
      cex_valid <= cex_valid_d;
      cex_in    <= cex_in_d;
      cex_out   <= cex_out_d;
      stop_lat  <= stop_lat_d;
    end
  end

  // Next-state and next-output logic. spec_ok/sk_out are only read in CHECK.
  always_comb begin
    state_d     = state;
    sk_in_d     = sk_in;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    fail_cnt_d  = fail_cnt;
    cex_valid_d = cex_valid;
    cex_in_d    = cex_in;
    cex_out_d   = cex_out;
    stop_lat_d  = stop_lat;
    fail_upd    = fail_cnt;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    if (abort) begin
      // Results are kept for debug; only the handshake flags drop.
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_d     = APPLY;
            sk_in_d     = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_cnt_d  = '0;
            cex_valid_d = 1'b0;
            cex_in_d    = '0;
            cex_out_d   = '0;
            stop_lat_d  = stop_on_fail;
            tmr_load    = 1'b1;
          end
        end
        APPLY: begin
          tmr_en = 1'b1;
          if (tmr_expire_c) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (!spec_ok) begin
            if (fail_cnt != FAIL_MAX) begin
              fail_upd = fail_cnt + (N_IN + 1)'(1);
            end
            if (!cex_valid) begin
              cex_valid_d = 1'b1;
              cex_in_d    = sk_in;
              cex_out_d   = sk_out;
            end
          end
          fail_cnt_d = fail_upd;
          if ((!spec_ok && stop_lat) || (sk_in == LAST_VEC)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_upd == '0);
          end else begin
            state_d  = APPLY;
            sk_in_d  = sk_in + N_IN'(1);
            tmr_load = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule : skolem_sweep_ctrl
